// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and helpers for time-multiplexed debouncers
// Provides the channel-index width used by the scheduler's pointer and a
// saturating increment shared by any debounce datapath.
package debounce_pkg;

    localparam int MAX_CH   = 16;
    localparam int CH_IDX_W = 4;
    // Working width for sat_inc; callers zero-extend their counter into it.
    localparam int SAT_W    = 32;

    // Increment cnt, saturating at 2^w-1 so a long-held difference never wraps
    // back to a small count.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                                 input int unsigned w);
        logic [SAT_W-1:0] max_v;
        max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (cnt >= max_v) ? max_v : cnt + SAT_W'(1);
    endfunction

endpackage

// File: rtl/debounce_slot.sv
// rtl/debounce_slot.sv - combinational debounce step for one channel visit
// Ports:
//   level, cnt, sample, thresh  : current state of the visited channel and threshold
//   next_level, next_cnt, accept: state to write back and the accept indication
module debounce_slot
    import debounce_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             level,
    input  logic [CNT_W-1:0] cnt,
    input  logic             sample,
    input  logic [CNT_W-1:0] thresh,
    output logic             next_level,
    output logic [CNT_W-1:0] next_cnt,
    output logic             accept
);

    logic [CNT_W-1:0] thr_eff;
    logic [SAT_W-1:0] inc_w;

    always_comb begin
        // A zero threshold behaves like one: the first differing visit accepts.
        thr_eff    = (thresh == '0) ? CNT_W'(1) : thresh;
        inc_w      = sat_inc(SAT_W'(cnt), CNT_W);
        next_level = level;
        next_cnt   = cnt;
        accept     = 1'b0;
        if (sample == level) begin
            // Any agreeing visit discards accumulated credit.
            next_cnt = '0;
        end else if (inc_w >= SAT_W'(thr_eff)) begin
            // >= so a threshold lowered below a stored count accepts at once.
            next_level = sample;
            next_cnt   = '0;
            accept     = 1'b1;
        end else begin
            next_cnt = inc_w[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - round-robin debouncer sharing one counter datapath
// Ports:
//   clk, rst (async active-low)
//   raw_in   : raw asynchronous inputs, one per channel
//   scan_div : clk cycles per scan slot minus 1
//   thresh   : differing samples needed to accept a change (0 acts as 1)
//   enable   : 1 = scanning runs, 0 = freeze pointer/prescaler/counters/levels
//   level    : debounced levels; rise/fall: one-cycle accept strobes
//   slot_ch  : channel currently pointed at
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     raw_in,
    input  logic [DIV_W-1:0]    scan_div,
    input  logic [CNT_W-1:0]    thresh,
    input  logic                enable,
    output logic [N_CH-1:0]     level,
    output logic [N_CH-1:0]     rise,
    output logic [N_CH-1:0]     fall,
    output logic [CH_IDX_W-1:0] slot_ch
);

    logic [N_CH-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DIV_W-1:0]    pre_q, pre_d;
    logic [CH_IDX_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q [N_CH];
    logic [CNT_W-1:0]    cnt_d [N_CH];
    logic [N_CH-1:0]     level_q, level_d, rise_q, rise_d, fall_q, fall_d;

    logic                slot_tick;
    logic                sel_level, sel_sample, nxt_level, accept;
    logic [CNT_W-1:0]    sel_cnt, nxt_cnt;

    // >= rather than == so that shrinking scan_div below the running count
    // produces a slot straight away instead of waiting for pre to wrap.
    assign slot_tick = enable && (pre_q >= scan_div);

    // Present the pointed-at channel's state to the shared datapath.
    always_comb begin
        sel_level  = 1'b0;
        sel_sample = 1'b0;
        sel_cnt    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == CH_IDX_W'(i)) begin
                sel_level  = level_q[i];
                sel_sample = sync2_q[i];
                sel_cnt    = cnt_q[i];
            end
        end
    end

    debounce_slot #(.CNT_W(CNT_W)) u_slot (
        .level      (sel_level),
        .cnt        (sel_cnt),
        .sample     (sel_sample),
        .thresh     (thresh),
        .next_level (nxt_level),
        .next_cnt   (nxt_cnt),
        .accept     (accept)
    );

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        pre_d   = pre_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        if (enable) begin
            pre_d = slot_tick ? '0 : pre_q + 1'b1;
        end
        if (slot_tick) begin
            ch_d = (ch_q == CH_IDX_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
            // Only the visited channel is written back, so at most one
            // channel can strobe in any cycle.
            for (int i = 0; i < N_CH; i++) begin
                if (ch_q == CH_IDX_W'(i)) begin
                    cnt_d[i]   = nxt_cnt;
                    level_d[i] = nxt_level;
                    rise_d[i]  = accept & nxt_level;
                    fall_d[i]  = accept & ~nxt_level;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
            ch_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pre_q   <= pre_d;
            ch_q    <= ch_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign slot_ch = ch_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - self-checking bench for debounce_scheduler
module tb_debounce_scheduler;

    localparam int N_CH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  raw_in = 4'hF;
    logic [7:0]  scan_div = 8'd0;
    logic [15:0] thresh = 16'd1;
    logic        enable = 1'b1;
    logic [3:0]  level, rise, fall, slot_ch;

    int checks = 0;
    int failures = 0;

    // Reference model: slot schedule, per-channel counts and levels as integers.
    int         m_pre, m_ch;
    int         m_cnt [N_CH];
    logic [3:0] m_level, m_rise, m_fall;
    logic [3:0] hist0, hist1;   // raw_in seen one and two edges ago

    always #5 clk = ~clk;

    debounce_scheduler #(.N_CH(4), .CNT_W(16), .DIV_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .scan_div (scan_div),
        .thresh   (thresh),
        .enable   (enable),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .slot_ch  (slot_ch)
    );

    function automatic void model_reset();
        m_pre = 0; m_ch = 0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        m_level = '0; m_rise = '0; m_fall = '0;
        hist0 = '0; hist1 = '0;
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_level, m_rise, m_fall, 4'(m_ch)};
    endfunction

    // One clock: advance the model with the inputs present at the edge,
    // then return at the falling edge for sampling.
    task automatic step();
        int thr, n;
        logic [3:0] samp;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            samp = hist1;
            m_rise = '0; m_fall = '0;
            if (enable && m_pre >= int'(scan_div)) begin
                thr = (thresh == 0) ? 1 : int'(thresh);
                if (samp[m_ch] == m_level[m_ch]) begin
                    m_cnt[m_ch] = 0;
                end else begin
                    n = m_cnt[m_ch] + 1;
                    if (n > 65535) n = 65535;
                    if (n >= thr) begin
                        m_level[m_ch] = samp[m_ch];
                        m_cnt[m_ch] = 0;
                        if (samp[m_ch]) m_rise[m_ch] = 1'b1;
                        else            m_fall[m_ch] = 1'b1;
                    end else begin
                        m_cnt[m_ch] = n;
                    end
                end
                m_ch = (m_ch + 1) % N_CH;
                m_pre = 0;
            end else if (enable) begin
                m_pre++;
            end
            hist1 = hist0;
            hist0 = raw_in;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold%0d: got %h expected 0000", i, {level, rise, fall, slot_ch});
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if ({level, rise, fall} !== 12'h0 || {level, rise, fall, slot_ch} !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", {level, rise, fall, slot_ch}, exp_vec());
        end
    endtask

    task automatic test_basic_accept();
        int nrise, other, lat;
        thresh = 16'd3; scan_div = 8'd0; enable = 1'b1; raw_in = 4'h0;
        for (int i = 0; i < 4; i++) step();
        nrise = 0; other = 0; lat = -1;
        raw_in[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL basic_cycle%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
            if (rise[2]) nrise++;
            if (((rise | fall) & 4'b1011) != 0) other++;
            if (level[2] && lat < 0) lat = i + 1;
        end
        checks++;
        if (nrise != 1) begin
            failures++;
            $display("FAIL basic_rise_count: got %0d expected 1", nrise);
        end
        checks++;
        if (other != 0) begin
            failures++;
            $display("FAIL basic_other_strobes: got %0d expected 0", other);
        end
        checks++;
        if (lat < 1 || lat > 14) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected 1..14", lat);
        end
    endtask

    task automatic test_glitch();
        int k;
        raw_in[1] = 1'b1;
        k = 0;
        while (m_cnt[1] != 2 && k < 40) begin
            step();
            k++;
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL glitch_rise_cycle%0d: got %h expected %h", k, {level, rise, fall, slot_ch}, exp_vec());
            end
        end
        checks++;
        if (k >= 40) begin
            failures++;
            $display("FAIL glitch_timeout: got %0d cycles expected <40", k);
        end
        raw_in[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL glitch_cycle%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
        end
        checks++;
        if (level[1] !== 1'b0 || dut.cnt_q[1] !== 16'd0) begin
            failures++;
            $display("FAIL glitch_cleared: got level=%b cnt=%0d expected level=0 cnt=0", level[1], dut.cnt_q[1]);
        end
    endtask

    task automatic test_thresh_change();
        int lat, bad, k;
        thresh = 16'd0;
        raw_in[3] = 1'b1;
        lat = -1; bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL thr0_cycle%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
            if (dut.cnt_q[3] !== 16'd0) bad++;
            if (rise[3] && lat < 0) lat = i + 1;
        end
        checks++;
        if (lat < 1 || lat > 6 || bad != 0) begin
            failures++;
            $display("FAIL thr0_accept: got lat=%0d partial=%0d expected lat 1..6 partial=0", lat, bad);
        end
        thresh = 16'd5;
        raw_in[0] = 1'b1;
        k = 0;
        while (m_cnt[0] != 3 && k < 60) begin
            step();
            k++;
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL thr5_cycle%0d: got %h expected %h", k, {level, rise, fall, slot_ch}, exp_vec());
            end
        end
        checks++;
        if (k >= 60 || dut.cnt_q[0] !== 16'd3) begin
            failures++;
            $display("FAIL thr5_count: got cnt=%0d after %0d cycles expected 3", dut.cnt_q[0], k);
        end
        thresh = 16'd2;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL thr2_cycle%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
            if (rise[0] && lat < 0) lat = i + 1;
        end
        checks++;
        if (lat < 1 || lat > 4 || level[0] !== 1'b1 || dut.cnt_q[0] !== 16'd0) begin
            failures++;
            $display("FAIL thr_lowered_accept: got lat=%0d level=%b cnt=%0d expected lat 1..4 level=1 cnt=0",
                     lat, level[0], dut.cnt_q[0]);
        end
    endtask

    task automatic test_prescaler_enable();
        int last, intervals;
        logic [3:0] prev, hold_ch, hold_lv;
        logic wrap;
        scan_div = 8'd3;
        last = -1; wrap = 1'b0; intervals = 0;
        prev = slot_ch;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL presc_cycle%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
            if (slot_ch != prev) begin
                if (last >= 0) begin
                    checks++;
                    intervals++;
                    if (i - last != 4) begin
                        failures++;
                        $display("FAIL presc_interval: got %0d expected 4", i - last);
                    end
                end
                if (prev == 4'd3 && slot_ch == 4'd0) wrap = 1'b1;
                last = i;
            end
            prev = slot_ch;
        end
        checks++;
        if (!wrap || intervals < 5) begin
            failures++;
            $display("FAIL presc_wrap: got wrap=%b intervals=%0d expected wrap=1 intervals>=5", wrap, intervals);
        end
        enable = 1'b0;
        hold_ch = slot_ch; hold_lv = level;
        raw_in = ~raw_in;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (slot_ch !== hold_ch || level !== hold_lv || {level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL enable_freeze%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
        end
        raw_in = ~raw_in;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_async_reset();
        int k, strobes;
        scan_div = 8'd0; thresh = 16'd5; raw_in = 4'h0;
        k = 0;
        while (m_cnt[0] != 2 && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (k >= 40 || dut.cnt_q[0] !== 16'd2) begin
            failures++;
            $display("FAIL areset_setup: got cnt=%0d after %0d cycles expected 2", dut.cnt_q[0], k);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({level, rise, fall, slot_ch} !== 16'h0 || dut.cnt_q[0] !== 16'd0) begin
            failures++;
            $display("FAIL areset_immediate: got %h cnt=%0d expected 0000 cnt=0", {level, rise, fall, slot_ch}, dut.cnt_q[0]);
        end
        step();
        step();
        rst = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL areset_release%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
            if ((rise | fall) != 0) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            failures++;
            $display("FAIL areset_no_strobe: got %0d expected 0", strobes);
        end
    endtask

    task automatic test_random();
        int multi;
        multi = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 0) begin
                thresh = 16'($urandom_range(3));
                scan_div = 8'($urandom_range(2));
            end
            if ($urandom_range(7) == 0) raw_in[$urandom_range(3)] ^= 1'b1;
            enable = ($urandom_range(9) != 0);
            step();
            checks++;
            if ({level, rise, fall, slot_ch} !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, {level, rise, fall, slot_ch}, exp_vec());
            end
            if ($countones(rise | fall) > 1) multi++;
        end
        checks++;
        if (multi != 0) begin
            failures++;
            $display("FAIL random_one_strobe: got %0d multi-strobe cycles expected 0", multi);
        end
    endtask

    initial begin
        test_reset();
        test_basic_accept();
        test_glitch();
        test_thresh_change();
        test_prescaler_enable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
